// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
//   mode_t / MODE_* : operation select encodings
//   state_t         : serializer control states
//   cnt_width()     : width of the serialize bit counter
package shift_reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_ROR  = 3'b101;
  localparam mode_t MODE_CLR  = 3'b110;
  localparam mode_t MODE_SER  = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dff_sync.sv
// Single-bit storage cell with synchronous active-high reset and enable.
//   clk     : rising-edge clock
//   rst     : synchronous reset, loads rst_val; overrides en
//   en      : when low the cell holds
//   rst_val : value taken on reset
//   d       : next value when enabled
//   q, qbar : stored bit and its complement
module dff_sync (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic rst_val,
  input  logic d,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else if (en) begin
      q <= d;
    end
  end

  // Derived from q directly so the pair can never disagree.
  assign qbar = ~q;

endmodule

// File: rtl/shift_register_universal.sv
// WIDTH-bit universal register: load, shift/rotate both ways, clear, and a
// self-timed LSB-first serialize mode with busy/done status.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   en           : operation/advance enable; low holds everything
//   mode         : operation select (see shift_reg_pkg)
//   d            : parallel data
//   sl_in, sr_in : serial inputs for shift left / shift right and serialize
//   q, qbar      : register contents and complement
//   sout         : serial output, q[0]
//   busy, done   : serialize in progress / one-cycle completion pulse
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | accepts any mode; SER loads d and starts a frame
// ST_SHIFT | shifting out one bit per enabled cycle; only CLR is honoured
module shift_register_universal
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sl_in,
  input  logic             sr_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] q_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    q_nxt     = q;
    if (en) begin
      unique case (state)
        ST_IDLE: begin
          case (mode)
            MODE_HOLD: q_nxt = q;
            MODE_LOAD: q_nxt = d;
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], sl_in};
            MODE_SHR:  q_nxt = {sr_in, q[WIDTH-1:1]};
            MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
            MODE_CLR:  q_nxt = '0;
            MODE_SER: begin
              q_nxt     = d;
              state_nxt = ST_SHIFT;
              cnt_nxt   = CW'(WIDTH);
            end
          endcase
        end
        ST_SHIFT: begin
          if (mode == MODE_CLR) begin
            // Abort: no completion pulse.
            q_nxt     = '0;
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            q_nxt   = {sr_in, q[WIDTH-1:1]};
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_sync u_bit (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .rst_val (RESET_VALUE[i]),
      .d       (q_nxt[i]),
      .q       (q[i]),
      .qbar    (qbar[i])
    );
  end

  assign sout = q[0];
  assign busy = (state == ST_SHIFT);

endmodule
